// File: rtl/jtdsp16_sdeser.sv
// rtl/jtdsp16_sdeser.sv - DSP16 serial output port receiver, left/right sample deserializer
module jtdsp16_sdeser #(
    parameter logic [7:0] LCHAN = 8'h00,
    parameter logic [7:0] RCHAN = 8'h01
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cen,
    input  logic        ock,
    input  logic        sdin,
    input  logic        old,
    input  logic        sadd,
    output logic [15:0] left,
    output logic [15:0] right,
    output logic        sample_ok,
    output logic [7:0]  word_addr,
    output logic        frame_err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;
    localparam logic [1:0] ST_WAIT  = 2'd3;

    logic [1:0]  state_q,     state_d;
    logic [4:0]  bit_cnt_q,   bit_cnt_d;
    logic [15:0] data_sh_q,   data_sh_d;
    logic [7:0]  addr_sh_q,   addr_sh_d;
    logic [15:0] left_q,      left_d;
    logic [15:0] right_q,     right_d;
    logic [7:0]  word_addr_q, word_addr_d;
    logic        sample_ok_q, sample_ok_d;
    logic        frame_err_q, frame_err_d;
    logic        lseen_q,     lseen_d;
    logic        rseen_q,     rseen_d;
    logic        last_ock_q;
    logic        ock_rise;

    // OCK rising edge as seen in the cen domain
    always_comb begin
        ock_rise = ock & ~last_ock_q;
    end

    // Frame FSM, shifters, commit and left/right pairing (next state assuming cen is high)
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        data_sh_d   = data_sh_q;
        addr_sh_d   = addr_sh_q;
        left_d      = left_q;
        right_d     = right_q;
        word_addr_d = word_addr_q;
        sample_ok_d = 1'b0;
        frame_err_d = frame_err_q;
        lseen_d     = lseen_q;
        rseen_d     = rseen_q;

        case (state_q)
            ST_IDLE: begin
                // The start rise only marks the frame; nothing is captured on it.
                if (ock_rise && !old) begin
                    state_d   = ST_SHIFT;
                    bit_cnt_d = 5'd0;
                end
            end
            ST_SHIFT: begin
                if (ock_rise) begin
                    if (old) begin
                        // OLD rising before 16 captures aborts the word.
                        state_d     = ST_IDLE;
                        bit_cnt_d   = 5'd0;
                        frame_err_d = 1'b1;
                    end else begin
                        data_sh_d = {data_sh_q[14:0], sdin};
                        if (bit_cnt_q < 5'd8) begin
                            addr_sh_d = {addr_sh_q[6:0], sadd};
                        end
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd15) begin
                            state_d = ST_DONE;
                        end
                    end
                end
            end
            ST_DONE: begin
                word_addr_d = addr_sh_q;
                if (addr_sh_q == LCHAN) begin
                    left_d  = data_sh_q;
                    lseen_d = 1'b1;
                end else if (addr_sh_q == RCHAN) begin
                    right_d = data_sh_q;
                    rseen_d = 1'b1;
                end
                state_d = ST_WAIT;
            end
            default: begin
                // Hold off until OLD goes high so the trailing low phase is not a new start.
                if (old) begin
                    state_d = ST_IDLE;
                end
            end
        endcase

        // Pair completes in the same cycle the second register loads.
        if (lseen_d && rseen_d) begin
            sample_ok_d = 1'b1;
            lseen_d     = 1'b0;
            rseen_d     = 1'b0;
        end
    end

    // State registers; everything, including edge detect, freezes while cen is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 5'd0;
            data_sh_q   <= 16'd0;
            addr_sh_q   <= 8'd0;
            left_q      <= 16'd0;
            right_q     <= 16'd0;
            word_addr_q <= 8'hFF;
            sample_ok_q <= 1'b0;
            frame_err_q <= 1'b0;
            lseen_q     <= 1'b0;
            rseen_q     <= 1'b0;
            last_ock_q  <= 1'b0;
        end else if (cen) begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            data_sh_q   <= data_sh_d;
            addr_sh_q   <= addr_sh_d;
            left_q      <= left_d;
            right_q     <= right_d;
            word_addr_q <= word_addr_d;
            sample_ok_q <= sample_ok_d;
            frame_err_q <= frame_err_d;
            lseen_q     <= lseen_d;
            rseen_q     <= rseen_d;
            last_ock_q  <= ock;
        end
    end

    assign left      = left_q;
    assign right     = right_q;
    assign word_addr = word_addr_q;
    assign sample_ok = sample_ok_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_jtdsp16_sdeser.sv
// tb/tb_jtdsp16_sdeser.sv - scoreboard bench for jtdsp16_sdeser
module tb_jtdsp16_sdeser;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cen = 1'b1;
    logic        ock, sdin, old, sadd;
    logic [15:0] left, right;
    logic        sample_ok;
    logic [7:0]  word_addr;
    logic        frame_err;

    typedef struct packed {
        logic [15:0] l;
        logic [15:0] r;
        logic [7:0]  a;
        logic        ok;
        logic        err;
    } exp_t;

    exp_t exp_q[$];

    int n_chk = 0;
    int n_pass = 0;
    int ok_seen = 0;
    int cen_div = 1;
    int cen_cnt = 0;

    logic [15:0] m_left, m_right;
    logic [7:0]  m_addr;
    logic        m_ls, m_rs, m_err;
    int          m_okc = 0;

    jtdsp16_sdeser #(.LCHAN(8'h00), .RCHAN(8'h01)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cen       (cen),
        .ock       (ock),
        .sdin      (sdin),
        .old       (old),
        .sadd      (sadd),
        .left      (left),
        .right     (right),
        .sample_ok (sample_ok),
        .word_addr (word_addr),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // cen pattern generated away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            cen_cnt = (cen_cnt + 1) % cen_div;
            cen = (cen_cnt == 0);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // advance to the next cen-qualified edge, then settle
    task automatic wait_cen();
        do @(posedge clk); while (!cen);
        #1;
        if (sample_ok) ok_seen++;
    endtask

    task automatic hold(input int n);
        repeat (n) wait_cen();
    endtask

    // low phase with the given pin values, then a rise detected at the returned edge
    task automatic ock_low_rise(input logic o, input logic d, input logic a);
        ock = 1'b0; old = o; sdin = d; sadd = a;
        hold(6);
        ock = 1'b1;
        wait_cen();
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0; ock = 1'b0; old = 1'b1; sdin = 1'b0; sadd = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check({tag, "_left"},  {16'd0, left},  32'h0);
        check({tag, "_right"}, {16'd0, right}, 32'h0);
        check({tag, "_addr"},  {24'd0, word_addr}, 32'hFF);
        check({tag, "_ok"},    {31'd0, sample_ok}, 32'h0);
        check({tag, "_err"},   {31'd0, frame_err}, 32'h0);
        m_left = 16'd0; m_right = 16'd0; m_addr = 8'hFF;
        m_ls = 1'b0; m_rs = 1'b0; m_err = 1'b0;
        rst_n = 1'b1;
        hold(3);
    endtask

    task automatic compare_pop(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            check({tag, "_empty"}, 32'd0, 32'd1);
            return;
        end
        e = exp_q.pop_front();
        check({tag, "_left"},  {16'd0, left},  {16'd0, e.l});
        check({tag, "_right"}, {16'd0, right}, {16'd0, e.r});
        check({tag, "_addr"},  {24'd0, word_addr}, {24'd0, e.a});
        check({tag, "_ok"},    {31'd0, sample_ok}, {31'd0, e.ok});
        check({tag, "_err"},   {31'd0, frame_err}, {31'd0, e.err});
    endtask

    // nb==16 sends a full word; smaller nb aborts with OLD high after nb bits
    task automatic send_frame(input string tag, input logic [7:0] addr,
                              input logic [15:0] data, input int nb);
        exp_t e;
        logic ok;
        ock_low_rise(1'b0, 1'b0, 1'b0);
        hold(5);
        for (int i = 0; i < nb; i++) begin
            ock_low_rise(1'b0, data[15-i], (i < 8) ? addr[7-i] : 1'b0);
            if (i < 15) hold(5);
        end
        if (nb == 16) begin
            check({tag, "_lat_left"},  {16'd0, left},  {16'd0, m_left});
            check({tag, "_lat_right"}, {16'd0, right}, {16'd0, m_right});
            if (addr == 8'h00) begin
                m_left = data; m_ls = 1'b1;
            end else if (addr == 8'h01) begin
                m_right = data; m_rs = 1'b1;
            end
            m_addr = addr;
            ok = m_ls && m_rs;
            if (ok) begin
                m_ls = 1'b0; m_rs = 1'b0; m_okc++;
            end
            e = '{l: m_left, r: m_right, a: m_addr, ok: ok, err: m_err};
            exp_q.push_back(e);
            wait_cen();
            compare_pop(tag);
            wait_cen();
            check({tag, "_ok_clear"}, {31'd0, sample_ok}, 32'h0);
            ock = 1'b0; old = 1'b1;
            hold(6);
        end else begin
            ock_low_rise(1'b1, 1'b0, 1'b0);
            m_err = 1'b1;
            e = '{l: m_left, r: m_right, a: m_addr, ok: 1'b0, err: 1'b1};
            exp_q.push_back(e);
            compare_pop(tag);
            hold(5);
            ock = 1'b0;
            hold(6);
        end
    endtask

    task automatic stereo(input string tag);
        send_frame({tag, "_l"}, 8'h00, 16'h1234, 16);
        send_frame({tag, "_r"}, 8'h01, 16'hFEDC, 16);
    endtask

    initial begin
        do_reset("rst0");
        send_frame("single", 8'h00, 16'h8001, 16);
        stereo("st1");
        send_frame("unk", 8'h5A, 16'h7777, 16);
        send_frame("abort", 8'h00, 16'h0BAD, 9);
        send_frame("post_ab_r", 8'h01, 16'h4321, 16);
        send_frame("post_ab_l", 8'h00, 16'h5555, 16);
        // reset mid-shift drops the partial word
        ock_low_rise(1'b0, 1'b0, 1'b0);
        hold(5);
        for (int i = 0; i < 5; i++) begin
            ock_low_rise(1'b0, 1'b1, 1'b1);
            hold(5);
        end
        do_reset("rst_mid");
        send_frame("post_rst", 8'h00, 16'hABCD, 16);
        cen_div = 3;
        do_reset("rst_cen");
        stereo("st3");
        check("ok_pulses", ok_seen, m_okc);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
